card_dealer: RTL and testbench
==============================

# card_dealer

Deals cards for the ten-and-a-half game from a 52-card deck without replacement, and sits directly upstream of the game controller. On each accepted request it picks a pseudo-random unused card and presents its rank, suit and point value in half-points. The game controller uses this value to drive the player/dealer FSM, the seven-segment display and the LEDs. A shuffle strobe returns all cards to the deck.

## Interface
- SEED, 6'h2B, LFSR reset value; must be nonzero.
- clk  in  1  system clock.
- rst_n  in  1  reset: asynchronous, active-low.
- shuffle  in  1  single-cycle strobe; clears the used-card map.
- req  in  1  single-cycle deal request; honoured only in IDLE.
- busy  out  1  high while a request is being serviced (SEARCH or DEAL).
- card_valid  out  1  one-cycle pulse; new card outputs are valid.
- card_idx  out  6  dealt card index, 0..51.
- rank  out  4  card rank, 1..13 (1 = A, 11/12/13 = J/Q/K).
- suit  out  2  card suit, 0..3.
- half_pts  out  5  card value ×2 (A..10 → 2..20; J/Q/K → 1).
- cards_left  out  6  undealt cards, 0..52.
- deck_empty  out  1  high when cards_left == 0.

## Operation
- Card index mapping:
  - rank = idx[5:2] + 1, suit = idx[1:0].
  - half_pts = 2·rank if rank ≤ 10, else 1.
- A 6-bit Fibonacci LFSR (x^6 + x^5 + 1) advances every clk, independent of FSM state.
- A 52-bit used map holds one bit per card; a bit set to 1 means that card has been dealt.
- The FSM has three states: IDLE, SEARCH, DEAL.
- **IDLE:**
  - Go to SEARCH when req=1, shuffle=0 and deck_empty=0.
  - Latch probe = lfsr, or lfsr − 52 if lfsr ≥ 52.
  - If req=1 with deck_empty=1, ignore it: stay in IDLE, no card_valid.
- **SEARCH:**
  - Test used[probe] once per cycle.
  - If the bit is clear, go to DEAL and register probe into card_idx, rank, suit and half_pts.
  - If the bit is set, probe = (probe == 51) ? 0 : probe + 1. This wrap-around is mandatory.
  - The search always succeeds within 52 probes, because entry requires cards_left ≥ 1.
- **DEAL:**
  - card_valid = 1 for this one cycle.
  - Set used[card_idx]; decrement cards_left.
  - Return to IDLE.
- Card outputs hold their values until the next DEAL.
- **Shuffle:**
  - Accepted in any state; clears the used map and sets cards_left = 52.
  - The FSM goes to IDLE.
  - A shuffle during SEARCH aborts the deal; no card_valid is produced.
  - A shuffle in DEAL still pulses card_valid that cycle, but the map is cleared afterwards and the card is not counted.
  - shuffle and req in the same cycle: shuffle wins and req is dropped.
- req while busy=1 is ignored; no queueing.

## Timing
- Reset values:
  - FSM in IDLE, lfsr = SEED.
  - used map all 0, cards_left = 52.
  - busy = 0, card_valid = 0, deck_empty = 0.
  - card_idx = 0, rank = 0, suit = 0, half_pts = 0.
- busy, card_valid, cards_left and deck_empty are all registered outputs.
- Deal latency, with req in cycle N and the free card found on probe k (k = 0..51):
  - SEARCH occupies cycles N+1 .. N+1+k.
  - card_valid = 1 in cycle N+2+k.
  - cards_left and deck_empty update in cycle N+3+k.
  - busy is high in cycles N+1 .. N+2+k.
  - Minimum latency is 2 cycles; maximum is 53.
- Shuffle in cycle N: cards_left = 52 and deck_empty = 0 from cycle N+1.
- Reset asserted mid-search: outputs return to reset values immediately, and the used map is cleared.

## Structure
- Shared package tenthirty_pkg holds:
  - DECK_SIZE = 52;
  - RANK_J / RANK_Q / RANK_K constants;
  - a half-point function from rank to half_pts, which the game controller also uses for totals (21 = 10.5).
- Sub-module lfsr6: SEED parameter, clk, rst_n, 6-bit state output.
- The used map, probe counter and FSM stay in card_dealer.

## Test plan
- **Reset:** hold rst_n=0, then release → cards_left = 52, deck_empty = 0, busy = 0, card_valid = 0, rank = 0.
- **Deal whole deck:** issue 52 reqs, each after the previous card_valid → 52 distinct card_idx values. cards_left steps 51..0, deck_empty = 1 after the 52nd deal, and every latency is ≤ 53 cycles.
- **Request on empty deck:** 53rd req → busy stays 0, no card_valid within 60 cycles, cards_left remains 0.
- **Value mapping:** check every dealt card against a reference model:
  - idx 39 → rank 10, suit 3, half_pts 20;
  - idx 40 → rank 11, suit 0, half_pts 1;
  - idx 0 → rank 1, half_pts 2.
- **Shuffle during SEARCH:** deal 50 cards so that search runs long, then pulse shuffle during SEARCH → no card_valid, and cards_left = 52 on the next cycle.
- **Simultaneous and busy requests:**
  - shuffle and req in the same cycle → busy stays 0, cards_left = 52.
  - req while busy → exactly one card_valid is produced.

Source files
------------

// File: rtl/tenthirty_pkg.sv
// Shared ten-and-a-half definitions: deck geometry, face-card ranks and card value helpers.
package tenthirty_pkg;

    localparam int unsigned DECK_SIZE = 52;
    localparam int unsigned IDX_W     = 6;
    localparam int unsigned RANK_W    = 4;
    localparam int unsigned SUIT_W    = 2;
    localparam int unsigned PTS_W     = 5;

    localparam logic [RANK_W-1:0] RANK_J = 4'd11;
    localparam logic [RANK_W-1:0] RANK_Q = 4'd12;
    localparam logic [RANK_W-1:0] RANK_K = 4'd13;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEARCH = 2'd1,
        ST_DEAL   = 2'd2
    } dealer_state_e;

    typedef struct packed {
        logic [IDX_W-1:0]  idx;
        logic [RANK_W-1:0] rank;
        logic [SUIT_W-1:0] suit;
        logic [PTS_W-1:0]  half_pts;
    } card_t;

    // Value in half-points; 21 represents a total of 10.5.
    function automatic logic [PTS_W-1:0] half_pts_of(input logic [RANK_W-1:0] rank);
        if (rank >= RANK_J) begin
            return 5'd1;
        end
        return PTS_W'({rank, 1'b0});
    endfunction

    function automatic card_t card_of(input logic [IDX_W-1:0] idx);
        card_t c;
        c.idx      = idx;
        c.rank     = idx[5:2] + 4'd1;
        c.suit     = idx[1:0];
        c.half_pts = half_pts_of(c.rank);
        return c;
    endfunction

endpackage

// File: rtl/lfsr6.sv
// Free-running 6-bit Fibonacci LFSR, polynomial x^6 + x^5 + 1 (period 63).
module lfsr6 #(
    parameter logic [5:0] SEED = 6'h2B
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [5:0] state_o
);

    logic [5:0] state_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SEED;
        end else begin
            state_q <= {state_q[4:0], state_q[5] ^ state_q[4]};
        end
    end

    assign state_o = state_q;

endmodule

// File: rtl/card_dealer.sv
// Deals pseudo-random cards from a 52-card deck without replacement.
module card_dealer
    import tenthirty_pkg::*;
#(
    parameter logic [5:0] SEED = 6'h2B
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              shuffle,
    input  logic              req,
    output logic              busy,
    output logic              card_valid,
    output logic [IDX_W-1:0]  card_idx,
    output logic [RANK_W-1:0] rank,
    output logic [SUIT_W-1:0] suit,
    output logic [PTS_W-1:0]  half_pts,
    output logic [IDX_W-1:0]  cards_left,
    output logic              deck_empty
);

    localparam logic [IDX_W-1:0] DECK_N  = IDX_W'(DECK_SIZE);
    localparam logic [IDX_W-1:0] LAST_IX = IDX_W'(DECK_SIZE - 1);

    logic [IDX_W-1:0]     lfsr;
    logic [IDX_W-1:0]     lfsr_mod;

    dealer_state_e        state_q, state_d;
    logic [DECK_SIZE-1:0] used_q, used_d;
    logic [IDX_W-1:0]     probe_q, probe_d;
    logic [IDX_W-1:0]     cards_left_q, cards_left_d;
    logic                 deck_empty_q, deck_empty_d;
    logic                 busy_q, busy_d;
    logic                 card_valid_q, card_valid_d;
    card_t                card_q, card_d;

    lfsr6 #(.SEED(SEED)) u_lfsr (
        .clk     (clk),
        .rst_n   (rst_n),
        .state_o (lfsr)
    );

    // Fold 52..63 back onto 0..11 so the first probe is always a legal index.
    assign lfsr_mod = (lfsr >= DECK_N) ? lfsr - DECK_N : lfsr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            used_q       <= '0;
            probe_q      <= '0;
            cards_left_q <= DECK_N;
            deck_empty_q <= 1'b0;
            busy_q       <= 1'b0;
            card_valid_q <= 1'b0;
            card_q       <= '0;
        end else begin
            state_q      <= state_d;
            used_q       <= used_d;
            probe_q      <= probe_d;
            cards_left_q <= cards_left_d;
            deck_empty_q <= deck_empty_d;
            busy_q       <= busy_d;
            card_valid_q <= card_valid_d;
            card_q       <= card_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        used_d       = used_q;
        probe_d      = probe_q;
        cards_left_d = cards_left_q;
        card_valid_d = 1'b0;
        card_d       = card_q;

        unique case (state_q)
            ST_IDLE: begin
                if (req && !deck_empty_q) begin
                    state_d = ST_SEARCH;
                    probe_d = lfsr_mod;
                end
            end
            ST_SEARCH: begin
                if (!used_q[probe_q]) begin
                    state_d      = ST_DEAL;
                    card_d       = card_of(probe_q);
                    card_valid_d = 1'b1;
                end else begin
                    probe_d = (probe_q == LAST_IX) ? '0 : probe_q + 6'd1;
                end
            end
            ST_DEAL: begin
                used_d[card_q.idx] = 1'b1;
                cards_left_d       = cards_left_q - 6'd1;
                state_d            = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Shuffle overrides everything, including a same-cycle request or a pending deal.
        if (shuffle) begin
            state_d      = ST_IDLE;
            used_d       = '0;
            cards_left_d = DECK_N;
            card_valid_d = 1'b0;
            card_d       = card_q;
        end

        busy_d       = (state_d != ST_IDLE);
        deck_empty_d = (cards_left_d == '0);
    end

    assign busy       = busy_q;
    assign card_valid = card_valid_q;
    assign card_idx   = card_q.idx;
    assign rank       = card_q.rank;
    assign suit       = card_q.suit;
    assign half_pts   = card_q.half_pts;
    assign cards_left = cards_left_q;
    assign deck_empty = deck_empty_q;

endmodule

// File: tb/tb_card_dealer.sv
// Self-checking bench for card_dealer: full-deck deals, value table, shuffle/req/reset corners.
module tb_card_dealer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       shuffle;
    logic       req;
    logic       busy;
    logic       card_valid;
    logic [5:0] card_idx;
    logic [3:0] rank;
    logic [1:0] suit;
    logic [4:0] half_pts;
    logic [5:0] cards_left;
    logic       deck_empty;

    card_dealer #(.SEED(6'h2B)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .shuffle    (shuffle),
        .req        (req),
        .busy       (busy),
        .card_valid (card_valid),
        .card_idx   (card_idx),
        .rank       (rank),
        .suit       (suit),
        .half_pts   (half_pts),
        .cards_left (cards_left),
        .deck_empty (deck_empty)
    );

    always #5 clk = ~clk;

    typedef struct {
        int idx;
        int exp_rank;
        int exp_suit;
        int exp_pts;
    } vec_t;

    int checks = 0;
    int passes = 0;
    int pts_tab [13] = '{2, 4, 6, 8, 10, 12, 14, 16, 18, 20, 1, 1, 1};
    bit seen [52];
    int seen_rank [52];
    int seen_suit [52];
    int seen_pts [52];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic clear_seen();
        for (int i = 0; i < 52; i++) seen[i] = 1'b0;
    endtask

    // Issue one request from IDLE and follow it through to the cards_left update.
    task automatic deal_one(output int got_idx);
        int  left_before;
        int  lat;
        bit  got;
        left_before = int'(cards_left);
        got = 1'b0;
        got_idx = -1;
        req = 1'b1;
        @(posedge clk); #1 req = 1'b0;
        lat = 1;
        chk("busy_after_req", int'(busy), 1);
        while (lat <= 60) begin
            @(negedge clk);
            if (card_valid) begin
                got = 1'b1;
                break;
            end
            @(posedge clk); #1;
            lat++;
        end
        chk("card_valid_seen", int'(got), 1);
        if (got) begin
            got_idx = int'(card_idx);
            chk("latency_le_53", int'(lat <= 53), 1);
            chk("latency_ge_2", int'(lat >= 2), 1);
            chk("map_rank", int'(rank), got_idx / 4 + 1);
            chk("map_suit", int'(suit), got_idx % 4);
            chk("map_pts", int'(half_pts), pts_tab[got_idx / 4]);
            chk("busy_in_deal", int'(busy), 1);
            chk("left_held_in_deal", int'(cards_left), left_before);
            @(posedge clk); #1;
            chk("left_after_deal", int'(cards_left), left_before - 1);
            chk("empty_after_deal", int'(deck_empty), int'(left_before == 1));
            chk("busy_after_deal", int'(busy), 0);
            chk("valid_one_cycle", int'(card_valid), 0);
        end
    endtask

    task automatic deal_n(input int n);
        int idx;
        for (int i = 0; i < n; i++) begin
            deal_one(idx);
            if (idx >= 0 && idx < 52) begin
                chk("distinct_idx", int'(seen[idx]), 0);
                seen[idx]      = 1'b1;
                seen_rank[idx] = int'(rank);
                seen_suit[idx] = int'(suit);
                seen_pts[idx]  = int'(half_pts);
            end else begin
                chk("idx_in_range", 0, 1);
            end
        end
    endtask

    task automatic pulse_shuffle();
        shuffle = 1'b1;
        @(posedge clk); #1 shuffle = 1'b0;
    endtask

    task automatic watch(input int cycles, output int n_valid, output int n_busy);
        n_valid = 0;
        n_busy  = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (card_valid) n_valid++;
            if (busy) n_busy++;
        end
        @(posedge clk); #1;
    endtask

    vec_t vecs [6];

    initial begin
        int nv, nb, all_seen;
        vecs[0] = '{39, 10, 3, 20};
        vecs[1] = '{40, 11, 0, 1};
        vecs[2] = '{0, 1, 0, 2};
        vecs[3] = '{51, 13, 3, 1};
        vecs[4] = '{36, 10, 0, 20};
        vecs[5] = '{5, 2, 1, 4};

        rst_n = 1'b0; req = 1'b0; shuffle = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cards_left", int'(cards_left), 52);
        chk("rst_deck_empty", int'(deck_empty), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_card_valid", int'(card_valid), 0);
        chk("rst_rank", int'(rank), 0);
        chk("rst_card_idx", int'(card_idx), 0);
        chk("rst_half_pts", int'(half_pts), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Whole deck.
        clear_seen();
        deal_n(52);
        chk("deck_empty_after_52", int'(deck_empty), 1);
        chk("cards_left_after_52", int'(cards_left), 0);
        all_seen = 0;
        for (int i = 0; i < 52; i++) all_seen += int'(seen[i]);
        chk("all_52_dealt", all_seen, 52);
        for (int i = 0; i < 6; i++) begin
            chk("vec_seen", int'(seen[vecs[i].idx]), 1);
            chk("vec_rank", seen_rank[vecs[i].idx], vecs[i].exp_rank);
            chk("vec_suit", seen_suit[vecs[i].idx], vecs[i].exp_suit);
            chk("vec_pts", seen_pts[vecs[i].idx], vecs[i].exp_pts);
        end

        // Request on an empty deck.
        req = 1'b1;
        @(posedge clk); #1 req = 1'b0;
        watch(60, nv, nb);
        chk("empty_req_no_valid", nv, 0);
        chk("empty_req_no_busy", nb, 0);
        chk("empty_req_left", int'(cards_left), 0);

        // Shuffle refills the deck on the next cycle.
        pulse_shuffle();
        chk("shuffle_left", int'(cards_left), 52);
        chk("shuffle_empty", int'(deck_empty), 0);

        // Shuffle during SEARCH after a long deal sequence.
        clear_seen();
        deal_n(50);
        chk("left_before_abort", int'(cards_left), 2);
        req = 1'b1;
        @(posedge clk); #1 req = 1'b0; shuffle = 1'b1;
        chk("busy_in_search", int'(busy), 1);
        @(posedge clk); #1 shuffle = 1'b0;
        chk("abort_left", int'(cards_left), 52);
        chk("abort_busy", int'(busy), 0);
        chk("abort_valid", int'(card_valid), 0);
        watch(60, nv, nb);
        chk("abort_no_valid", nv, 0);

        // Shuffle and req together: shuffle wins.
        req = 1'b1; shuffle = 1'b1;
        @(posedge clk); #1 req = 1'b0; shuffle = 1'b0;
        chk("simul_busy", int'(busy), 0);
        chk("simul_left", int'(cards_left), 52);
        watch(10, nv, nb);
        chk("simul_no_valid", nv, 0);
        chk("simul_no_busy", nb, 0);

        // Shuffle during DEAL: pulse still seen, card not counted.
        req = 1'b1;
        @(posedge clk); #1 req = 1'b0;
        nv = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (card_valid) begin
                nv = 1;
                break;
            end
        end
        chk("deal_shuffle_valid", nv, 1);
        shuffle = 1'b1;
        @(posedge clk); #1 shuffle = 1'b0;
        chk("deal_shuffle_left", int'(cards_left), 52);
        chk("deal_shuffle_busy", int'(busy), 0);

        // Request while busy is ignored.
        req = 1'b1;
        @(posedge clk); #1;
        chk("rwb_busy", int'(busy), 1);
        @(posedge clk); #1 req = 1'b0;
        watch(60, nv, nb);
        chk("rwb_one_valid", nv, 1);
        chk("rwb_left", int'(cards_left), 51);

        // Reset asserted mid-search.
        req = 1'b1;
        @(posedge clk); #1 req = 1'b0;
        chk("pre_rst_busy", int'(busy), 1);
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_left", int'(cards_left), 52);
        chk("midrst_rank", int'(rank), 0);
        chk("midrst_valid", int'(card_valid), 0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // Map must be clear after reset: the whole deck deals again.
        clear_seen();
        deal_n(52);
        chk("redeal_empty", int'(deck_empty), 1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
